// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The producer of operands and consumer of results uses the master modport.
interface serial_adder_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: two half-add cells plus a carry flop, one bit per clock, LSB first.
// Operands are captured on accept; sum/cout update only when the last bit has been produced.
module serial_adder #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_sr_q, a_sr_d;
  logic [W-1:0]     b_sr_q, b_sr_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s0, c0;
  logic             bit_s, c1;
  logic             carry_nx;
  logic [W-1:0]     res_shift;

  // Half-add cell: returns {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  assign {c0, s0}    = ha(a_sr_q[0], b_sr_q[0]);
  assign {c1, bit_s} = ha(s0, carry_q);
  assign carry_nx    = c0 | c1;

  // New bit enters at the MSB so that after W shifts the LSB lands at bit 0.
  assign res_shift = (res_q >> 1) | (W'(bit_s) << (W - 1));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = res_shift;
        carry_d = carry_nx;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = res_shift;
          cout_d  = carry_nx;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_ready is gated by rst directly so it drops the moment reset is asserted.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder: driver pushes a+b+cin into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.W(W)) bus ();

  serial_adder #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_acc = -1;
  logic [W:0] exp_q[$];
  int acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: samples just after the falling edge, after the driver has settled inputs.
  logic prev_ov = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          int a0;
          a0 = acc_q.pop_front();
          check("latency", cyc - a0, W);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("result", int'({bus.cout, bus.sum}), int'(e));
          $display("result a+b+cin: got cout=%0d sum=0x%0h expected 0x%0h", bus.cout, bus.sum, e);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input bit keep);
    int n;
    n = 0;
    bus.a = av;
    bus.b = bv;
    bus.cin = cv;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = keep;
      return;
    end
    exp_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv});
    acc_q.push_back(cyc + 1);
    if (keep && last_acc >= 0) check("issue_interval", cyc + 1 - last_acc, W + 2);
    last_acc = cyc + 1;
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_sum", int'(bus.sum), 0);
    check("rst_cout", int'(bus.cout), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);

    send(8'h3C, 8'h0F, 1'b0, 1'b0); drain();
    send(8'hFF, 8'h01, 1'b0, 1'b0); drain();
    send(8'hFF, 8'hFF, 1'b1, 1'b0); drain();
    send(8'h00, 8'h00, 1'b1, 1'b0); drain();

    // Backpressure: hold the result while a new bundle waits at the input.
    bus.out_ready = 1'b0;
    send(8'h55, 8'h66, 1'b1, 1'b0);
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("bp_out_valid_rise", int'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b1;
    bus.a = 8'h11;
    bus.b = 8'h22;
    bus.cin = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_sum", int'(bus.sum), 'hBC);
      check("bp_cout", int'(bus.cout), 0);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (2 * W) @(negedge clk);
    #1;
    check("no_queued_accept", int'(bus.out_valid), 0);
    @(negedge clk);

    // Reset during RUN discards the operation.
    send(8'hA5, 8'h5A, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_sum", int'(bus.sum), 0);
    check("midrst_cout", int'(bus.cout), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    send(8'h12, 8'h34, 1'b0, 1'b0); drain();

    // Back-to-back random traffic with in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
    bus.in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
